// File: rtl/parking_lot_occupancy.sv
// Parking lot occupancy counter: saturating car count, full/empty flags, sticky
// event errors and a six-digit active-low 7-segment status display.
module parking_lot_occupancy #(
    parameter int CAPACITY = 25,
    parameter int WIDTH    = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enter,
    input  logic             exit,
    output logic [WIDTH-1:0] count,
    output logic             full,
    output logic             empty,
    output logic             ovf_err,
    output logic             unf_err,
    output logic [6:0]       HEX5,
    output logic [6:0]       HEX4,
    output logic [6:0]       HEX3,
    output logic [6:0]       HEX2,
    output logic [6:0]       HEX1,
    output logic [6:0]       HEX0
);

    localparam logic [WIDTH-1:0] CAP = WIDTH'(CAPACITY);

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_C     = 7'b1000110;
    localparam logic [6:0] SEG_L     = 7'b1000111;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_R     = 7'b0101111;
    localparam logic [6:0] SEG_F     = 7'b0001110;
    localparam logic [6:0] SEG_U     = 7'b1000001;

    function automatic logic [6:0] seg_digit(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return SEG_BLANK;
        endcase
    endfunction

    // Simultaneous enter and exit cancel out and never raise an error.
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            count   <= '0;
            ovf_err <= 1'b0;
            unf_err <= 1'b0;
        end else begin
            case ({enter, exit})
                2'b10: begin
                    if (count < CAP) count <= count + WIDTH'(1);
                    else             ovf_err <= 1'b1;
                end
                2'b01: begin
                    if (count != '0) count <= count - WIDTH'(1);
                    else             unf_err <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign full  = (count == CAP);
    assign empty = (count == '0);

    int         value;
    int         tens;
    logic [3:0] tens_d;
    logic [3:0] units_d;

    // Divide-free decimal split: count never exceeds 99.
    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        value = 32'(count);
        tens  = 0;
        for (int t = 1; t <= 9; t++) begin
            if (value >= 10 * t) tens = t;
        end
        tens_d  = 4'(tens);
        units_d = 4'(value - 10 * tens);
    end

    always_comb begin
        HEX5 = SEG_BLANK;
        HEX4 = SEG_BLANK;
        HEX3 = SEG_BLANK;
        HEX2 = SEG_BLANK;
        HEX1 = SEG_BLANK;
        HEX0 = seg_digit(units_d);
        if (empty) begin
            HEX5 = SEG_C;
            HEX4 = SEG_L;
            HEX3 = SEG_E;
            HEX2 = SEG_A;
            HEX1 = SEG_R;
        end else if (full) begin
            HEX5 = SEG_F;
            HEX4 = SEG_U;
            HEX3 = SEG_L;
            HEX2 = SEG_L;
            HEX1 = seg_digit(tens_d);
        end else if (tens_d != 4'd0) begin
            HEX1 = seg_digit(tens_d);
        end
    end

endmodule
